// File: rtl/kalman_state_uart_tx_if.sv
// kalman_state_uart_tx_if
//   Bundles the filter-to-UART handshake for kalman_state_uart_tx.
//   master : filter side, drives State/send and observes status + tx line.
//   slave  : UART transmitter side.
//   Signals: State[0:nos-1] (WIDTH bits each), send, busy, done, overrun, tx.
interface kalman_state_uart_tx_if #(
   parameter int WIDTH = 16,
   parameter int nos   = 3
);
   logic [WIDTH-1:0] State [0:nos-1];
   logic             send;
   logic             busy;
   logic             done;
   logic             overrun;
   logic             tx;

   modport master (
      output State,
      output send,
      input  busy,
      input  done,
      input  overrun,
      input  tx
   );

   modport slave (
      input  State,
      input  send,
      output busy,
      output done,
      output overrun,
      output tx
   );
endinterface

// File: rtl/kalman_state_uart_tx.sv
// kalman_state_uart_tx
//   Snapshots the Kalman filter state vector on a send request and serialises
//   it as a UART 8N1 frame: HEADER, then State[0..nos-1], each word MSB byte
//   first. Bytes are sent back-to-back with no idle gap.
//   Optional macro KALMAN_UART_CHECKSUM_EN appends one byte holding the XOR of
//   all data bytes (HEADER excluded).
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   clk_en : global clock enable; all state advances only when high
//   bus    : slave modport carrying State, send, busy, done, overrun, tx
module kalman_state_uart_tx #(
   parameter int         WIDTH        = 16,
   parameter int         nos          = 3,
   parameter int         CLKS_PER_BIT = 868,
   parameter logic [7:0] HEADER       = 8'hA5
) (
   input logic                   clk,
   input logic                   reset,
   input logic                   clk_en,
   kalman_state_uart_tx_if.slave bus
);
   localparam int DATA_BYTES = nos * WIDTH / 8;
`ifdef KALMAN_UART_CHECKSUM_EN
   localparam int N_BYTES    = DATA_BYTES + 2;
`else
   localparam int N_BYTES    = DATA_BYTES + 1;
`endif
   localparam int SHADOW_W   = nos * WIDTH;
   localparam int BAUD_W     = $clog2(CLKS_PER_BIT);
   localparam int IDX_W      = $clog2(N_BYTES + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_BYTES - 1);

   logic [1:0]          state_q,   state_d;
   logic [BAUD_W-1:0]   baud_q,    baud_d;
   logic [2:0]          bit_q,     bit_d;
   logic [IDX_W-1:0]    idx_q,     idx_d;
   logic [7:0]          byte_q,    byte_d;
   logic [SHADOW_W-1:0] shadow_q,  shadow_d;
   logic                tx_q,      tx_d;
   logic                done_q,    done_d;
   logic                overrun_q, overrun_d;
`ifdef KALMAN_UART_CHECKSUM_EN
   logic [7:0]          csum_q,    csum_d;
`endif
   logic [SHADOW_W-1:0] state_flat;
   logic                bit_end;

   // State[0] lands in the top bits so the shadow can be shifted out MSB-byte first.
   always_comb begin
      state_flat = '0;
      for (int unsigned w = 0; w < nos; w++) begin
         state_flat[(nos - 1 - w) * WIDTH +: WIDTH] = bus.State[w];
      end
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      idx_d     = idx_q;
      byte_d    = byte_q;
      shadow_d  = shadow_q;
      tx_d      = tx_q;
      done_d    = done_q;
      overrun_d = overrun_q;
`ifdef KALMAN_UART_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      bit_end   = (baud_q == BAUD_LAST);

      if (clk_en) begin
         done_d = 1'b0;
         if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
         end

         case (state_q)
            IDLE: begin
               if (bus.send) begin
                  state_d  = START;
                  tx_d     = 1'b0;
                  baud_d   = '0;
                  idx_d    = '0;
                  byte_d   = HEADER;
                  shadow_d = state_flat;
`ifdef KALMAN_UART_CHECKSUM_EN
                  csum_d   = '0;
`endif
               end
            end
            START: begin
               if (bit_end) begin
                  state_d = DATA;
                  bit_d   = '0;
                  tx_d    = byte_q[0];
               end
            end
            DATA: begin
               // byte_q is shifted right per bit, so the next bit is always byte_q[1].
               if (bit_end) begin
                  if (bit_q == 3'd7) begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end else begin
                     bit_d  = bit_q + 3'd1;
                     byte_d = byte_q >> 1;
                     tx_d   = byte_q[1];
                  end
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (idx_q == IDX_LAST) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                     tx_d    = 1'b1;
                  end else begin
                     state_d = START;
                     tx_d    = 1'b0;
                     idx_d   = idx_q + IDX_W'(1);
`ifdef KALMAN_UART_CHECKSUM_EN
                     // Checksum accumulates as each data byte leaves the shadow.
                     if (idx_q == IDX_W'(DATA_BYTES)) begin
                        byte_d = csum_q;
                     end else begin
                        byte_d   = shadow_q[SHADOW_W-1 -: 8];
                        shadow_d = shadow_q << 8;
                        csum_d   = csum_q ^ shadow_q[SHADOW_W-1 -: 8];
                     end
`else
                     byte_d   = shadow_q[SHADOW_W-1 -: 8];
                     shadow_d = shadow_q << 8;
`endif
                  end
               end
            end
         endcase

         if (bus.send && (state_q != IDLE)) begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         idx_q     <= '0;
         byte_q    <= '0;
         shadow_q  <= '0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
`ifdef KALMAN_UART_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         idx_q     <= idx_d;
         byte_q    <= byte_d;
         shadow_q  <= shadow_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
`ifdef KALMAN_UART_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign bus.tx      = tx_q;
   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = done_q;
   assign bus.overrun = overrun_q;
endmodule
